// File: rtl/rr_mux4_sched.sv
// rr_mux4_sched -- four-source round-robin multiplexer with a one-word
// registered output stage.
//
// Ports
//   clk        : single clock, rising-edge active
//   rst_n      : asynchronous active-low reset
//   req[3:0]   : request per source (0=a, 1=b, 2=c, 3=d)
//   a,b,c,d    : source data, valid while the matching req bit is high
//   ack[3:0]   : one-hot pulse, source i's data is captured this cycle
//   out_valid  : output register holds an untransferred word
//   out_ready  : downstream accepts; transfer when out_valid & out_ready
//   out_data   : registered selected data
//   sel        : index of the source that supplied out_data
//   busy       : high while the output register is full
module rr_mux4_sched #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   output logic [3:0]       ack,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       sel,
   output logic             busy
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_data;
   logic [1:0]       r_sel;
   logic [1:0]       r_ptr;

   logic             w_capture;
   logic [1:0]       w_win;
   logic [WIDTH-1:0] w_src;

   // First set request bit searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
   function automatic logic [1:0] rr_pick(input logic [3:0] rq, input logic [1:0] p);
      logic [1:0] idx;
      logic       found;
      rr_pick = p;
      found   = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = p + k[1:0];
         if (!found && rq[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

   // Capture decision and winner; the output register is free in IDLE or
   // when its current word is being taken this cycle.
   always_comb begin
      w_capture = 1'b0;
      w_win     = rr_pick(req, r_ptr);
      if (((r_state == IDLE) || out_ready) && (req != 4'b0000)) begin
         w_capture = 1'b1;
      end else begin
         w_capture = 1'b0;
      end
   end

   // 4:1 data select on the winner.
   always_comb begin
      w_src = a;
      case (w_win)
         2'd0:    w_src = a;
         2'd1:    w_src = b;
         2'd2:    w_src = c;
         2'd3:    w_src = d;
         default: w_src = a;
      endcase
   end

   // Ack pulse; held low while reset is asserted so no source sees a grant
   // that the register cannot keep.
   always_comb begin
      ack = 4'b0000;
      if (rst_n && w_capture) begin
         ack = 4'b0001 << w_win;
      end else begin
         ack = 4'b0000;
      end
   end

   // Output-stage FSM: load on capture, drain to IDLE when taken with no
   // new request; sel/data keep their last values when draining.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_data  <= {WIDTH{1'b0}};
         r_sel   <= 2'b00;
         r_ptr   <= 2'b11;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_capture) begin
                  r_state <= HOLD;
                  r_data  <= w_src;
                  r_sel   <= w_win;
                  r_ptr   <= w_win;
               end
            end
            HOLD: begin
               if (w_capture) begin
                  r_data <= w_src;
                  r_sel  <= w_win;
                  r_ptr  <= w_win;
               end else if (out_ready) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign out_valid = (r_state == HOLD);
   assign busy      = (r_state == HOLD);
   assign out_data  = r_data;
   assign sel       = r_sel;

endmodule
